// File: rtl/vfu_mask_router_if.sv
// rtl/vfu_mask_router_if.sv - ticket push, mask broadcast and FU mask ports of vfu_mask_router
interface vfu_mask_router_if #(
   parameter int BeatW = 16,
   parameter int IdW   = 3,
   parameter int StrbW = 8
);
   logic             push_valid_i;
   logic             push_ready_o;
   logic             push_fu_i;
   logic [BeatW-1:0] push_beats_i;
   logic [IdW-1:0]   push_id_i;
   logic [StrbW-1:0] mask_i;
   logic             mask_valid_i;
   logic             mask_ready_o;
   logic [StrbW-1:0] alu_mask_o;
   logic             alu_mask_valid_o;
   logic             alu_mask_ready_i;
   logic [StrbW-1:0] mfpu_mask_o;
   logic             mfpu_mask_valid_o;
   logic             mfpu_mask_ready_i;
   logic             head_valid_o;
   logic [IdW-1:0]   head_id_o;
   logic             err_o;
   logic [31:0]      alu_beats_o;
   logic [31:0]      mfpu_beats_o;

   modport master (
      output push_valid_i, push_fu_i, push_beats_i, push_id_i,
      output mask_i, mask_valid_i, alu_mask_ready_i, mfpu_mask_ready_i,
      input  push_ready_o, mask_ready_o, alu_mask_o, alu_mask_valid_o,
      input  mfpu_mask_o, mfpu_mask_valid_o, head_valid_o, head_id_o,
      input  err_o, alu_beats_o, mfpu_beats_o
   );

   modport slave (
      input  push_valid_i, push_fu_i, push_beats_i, push_id_i,
      input  mask_i, mask_valid_i, alu_mask_ready_i, mfpu_mask_ready_i,
      output push_ready_o, mask_ready_o, alu_mask_o, alu_mask_valid_o,
      output mfpu_mask_o, mfpu_mask_valid_o, head_valid_o, head_id_o,
      output err_o, alu_beats_o, mfpu_beats_o
   );
endinterface

// File: rtl/vfu_mask_router.sv
// rtl/vfu_mask_router.sv - per-lane mask beat router to ALU/MFPU by in-order ownership tickets
// Optional beat counters: VFU_MASK_ROUTER_PERF_EN
module vfu_mask_router #(
   parameter int Depth = 4,
   parameter int BeatW = 16,
   parameter int IdW   = 3,
   parameter int StrbW = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   vfu_mask_router_if.slave  bus
);
   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;
   localparam logic [BeatW-1:0] BEAT_ONE = BeatW'(1);

   typedef enum logic {ST_EMPTY, ST_ACTIVE} state_t;

   logic             r_fu    [Depth];
   logic [BeatW-1:0] r_beats [Depth];
   logic [IdW-1:0]   r_id    [Depth];
   logic [PtrW-1:0]  r_wptr;
   logic [PtrW-1:0]  r_rptr;
   logic [CntW-1:0]  r_count;
   logic [BeatW-1:0] r_cons;
   logic             r_err;
   state_t           r_state;
   state_t           w_state_nxt;

   logic             w_full;
   logic             w_push_ready;
   logic             w_push_hs;
   logic             w_enq;
   logic             w_zero;
   logic             w_head_valid;
   logic             w_head_fu;
   logic [BeatW-1:0] w_head_beats;
   logic [StrbW-1:0] w_mask;
   logic             w_owner_ready;
   logic             w_mask_ready;
   logic             w_beat_hs;
   logic             w_pop;

   assign w_full       = (r_count == CntW'(Depth));
   assign w_push_ready = !w_full && !rst_i;
   assign w_push_hs    = bus.push_valid_i && w_push_ready;
   assign w_enq        = w_push_hs && (bus.push_beats_i != '0);
   assign w_zero       = w_push_hs && (bus.push_beats_i == '0);

   assign w_head_valid = (r_state == ST_ACTIVE);
   assign w_head_fu    = r_fu[r_rptr];
   assign w_head_beats = r_beats[r_rptr];

   // Both FUs see the broadcast; only the head ticket's owner gets a valid.
   assign w_mask        = bus.mask_i;
   assign w_owner_ready = w_head_fu ? bus.mfpu_mask_ready_i : bus.alu_mask_ready_i;
   assign w_mask_ready  = w_owner_ready && w_head_valid && !rst_i;
   assign w_beat_hs     = bus.mask_valid_i && w_mask_ready;
   assign w_pop         = w_beat_hs && ((r_cons + BEAT_ONE) == w_head_beats);

   assign bus.push_ready_o      = w_push_ready;
   assign bus.mask_ready_o      = w_mask_ready;
   assign bus.alu_mask_o        = w_mask;
   assign bus.mfpu_mask_o       = w_mask;
   assign bus.alu_mask_valid_o  = bus.mask_valid_i && w_head_valid && !w_head_fu;
   assign bus.mfpu_mask_valid_o = bus.mask_valid_i && w_head_valid && w_head_fu;
   assign bus.head_valid_o      = w_head_valid;
   assign bus.head_id_o         = w_head_valid ? r_id[r_rptr] : '0;
   assign bus.err_o             = r_err;

   always_ff @(posedge clk_i) begin
      if (w_enq) begin
         r_fu[r_wptr]    <= bus.push_fu_i;
         r_beats[r_wptr] <= bus.push_beats_i;
         r_id[r_wptr]    <= bus.push_id_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_cons  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_zero;
         if (w_enq) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
            r_cons <= '0;
         end else if (w_beat_hs) begin
            r_cons <= r_cons + BEAT_ONE;
         end
         if (w_enq && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_enq && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_enq) begin
               w_state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (w_pop && (r_count == CntW'(1)) && !w_enq) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

`ifdef VFU_MASK_ROUTER_PERF_EN
   logic [31:0] r_alu_beats;
   logic [31:0] r_mfpu_beats;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_alu_beats  <= '0;
         r_mfpu_beats <= '0;
      end else if (w_beat_hs) begin
         if (w_head_fu) begin
            r_mfpu_beats <= r_mfpu_beats + 32'd1;
         end else begin
            r_alu_beats <= r_alu_beats + 32'd1;
         end
      end
   end

   assign bus.alu_beats_o  = r_alu_beats;
   assign bus.mfpu_beats_o = r_mfpu_beats;
`else
   assign bus.alu_beats_o  = '0;
   assign bus.mfpu_beats_o = '0;
`endif
endmodule

// File: tb/tb_vfu_mask_router.sv
// tb/tb_vfu_mask_router.sv - directed bench with ticket scoreboard for vfu_mask_router
module tb_vfu_mask_router;
   localparam int Depth = 4;

   typedef struct {
      logic       fu;
      int         rem;
      logic [2:0] id;
   } tkt_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   m_alu = 0;
   int   m_mfpu = 0;
   tkt_t tq[$];

   vfu_mask_router_if #(.BeatW(16), .IdW(3), .StrbW(8)) bus ();

   vfu_mask_router #(.Depth(Depth), .BeatW(16), .IdW(3), .StrbW(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag);
      chk({tag, "_head_valid"}, 32'(bus.head_valid_o), 32'(tq.size() != 0));
      chk({tag, "_head_id"}, 32'(bus.head_id_o), (tq.size() != 0) ? 32'(tq[0].id) : 32'd0);
   endtask

   task automatic chk_perf(input string tag);
`ifdef VFU_MASK_ROUTER_PERF_EN
      chk({tag, "_alu_beats"}, bus.alu_beats_o, 32'(m_alu));
      chk({tag, "_mfpu_beats"}, bus.mfpu_beats_o, 32'(m_mfpu));
`else
      chk({tag, "_alu_beats"}, bus.alu_beats_o, 32'd0);
      chk({tag, "_mfpu_beats"}, bus.mfpu_beats_o, 32'd0);
`endif
   endtask

   task automatic push(input string tag, input logic fu, input logic [15:0] b, input logic [2:0] id);
      logic hs;
      tkt_t t;
      bus.push_valid_i = 1'b1;
      bus.push_fu_i    = fu;
      bus.push_beats_i = b;
      bus.push_id_i    = id;
      #1;
      hs = (tq.size() < Depth);
      chk({tag, "_push_ready"}, 32'(bus.push_ready_o), 32'(hs));
      @(posedge clk);
      if (hs && b != 16'd0) begin
         t.fu = fu; t.rem = int'(b); t.id = id;
         tq.push_back(t);
      end
      #1;
      bus.push_valid_i = 1'b0;
      chk({tag, "_err"}, 32'(bus.err_o), 32'(hs && b == 16'd0));
      chk_head(tag);
   endtask

   task automatic beat(input string tag, input logic [7:0] d, input logic ar, input logic mr);
      logic have, own, hs;
      tkt_t t;
      bus.mask_valid_i      = 1'b1;
      bus.mask_i            = d;
      bus.alu_mask_ready_i  = ar;
      bus.mfpu_mask_ready_i = mr;
      #1;
      have = (tq.size() != 0);
      own  = have ? tq[0].fu : 1'b0;
      hs   = have && (own ? mr : ar);
      chk({tag, "_alu_valid"}, 32'(bus.alu_mask_valid_o), 32'(have && !own));
      chk({tag, "_mfpu_valid"}, 32'(bus.mfpu_mask_valid_o), 32'(have && own));
      chk({tag, "_mask_ready"}, 32'(bus.mask_ready_o), 32'(hs));
      chk({tag, "_fwd_data"}, {16'd0, bus.alu_mask_o, bus.mfpu_mask_o}, {16'd0, d, d});
      @(posedge clk);
      if (hs) begin
         if (own) m_mfpu++; else m_alu++;
         t = tq.pop_front();
         t.rem--;
         if (t.rem != 0) tq.push_front(t);
      end
      #1;
      bus.mask_valid_i = 1'b0;
      chk_head(tag);
   endtask

   task automatic idle(input string tag);
      bus.mask_valid_i = 1'b0;
      bus.push_valid_i = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_err"}, 32'(bus.err_o), 32'd0);
      chk_head(tag);
   endtask

   initial begin
      bus.push_valid_i      = 1'b1;
      bus.push_fu_i         = 1'b0;
      bus.push_beats_i      = 16'd1;
      bus.push_id_i         = 3'd5;
      bus.mask_i            = 8'h00;
      bus.mask_valid_i      = 1'b1;
      bus.alu_mask_ready_i  = 1'b1;
      bus.mfpu_mask_ready_i = 1'b1;

      // Reset with live requests: nothing may handshake.
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_push_ready", 32'(bus.push_ready_o), 32'd0);
      chk("rst_mask_ready", 32'(bus.mask_ready_o), 32'd0);
      chk("rst_alu_valid", 32'(bus.alu_mask_valid_o), 32'd0);
      chk("rst_mfpu_valid", 32'(bus.mfpu_mask_valid_o), 32'd0);
      chk("rst_err", 32'(bus.err_o), 32'd0);
      chk_head("rst");
      chk_perf("rst");
      bus.push_valid_i = 1'b0;
      bus.mask_valid_i = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_push_ready", 32'(bus.push_ready_o), 32'd1);

      // Single ticket
      push("single_push", 1'b0, 16'd3, 3'd2);
      beat("single_b0", 8'hAA, 1'b1, 1'b1);
      beat("single_b1", 8'h55, 1'b1, 1'b1);
      beat("single_b2", 8'hFF, 1'b1, 1'b1);
      chk("single_done_empty", 32'(bus.head_valid_o), 32'd0);

      // Interleaved owners, back-to-back beats
      push("il_p0", 1'b0, 16'd2, 3'd1);
      push("il_p1", 1'b1, 16'd2, 3'd3);
      push("il_p2", 1'b0, 16'd1, 3'd4);
      beat("il_b0", 8'h01, 1'b1, 1'b1);
      beat("il_b1", 8'h02, 1'b1, 1'b1);
      beat("il_b2", 8'h03, 1'b1, 1'b1);
      beat("il_b3", 8'h04, 1'b1, 1'b1);
      beat("il_b4", 8'h05, 1'b1, 1'b1);

      // Backpressure from MFPU while ALU is ready
      push("bp_push", 1'b1, 16'd2, 3'd5);
      for (int i = 0; i < 4; i++) beat("bp_stall", 8'hC3, 1'b1, 1'b0);
      beat("bp_b0", 8'hC3, 1'b1, 1'b1);
      beat("bp_b1", 8'h3C, 1'b1, 1'b1);

      // Fill the FIFO, then try a push alongside a pop
      for (int i = 0; i < 4; i++) push("full_fill", 1'b0, 16'd1, 3'(i));
      push("full_reject", 1'b1, 16'd1, 3'd7);
      bus.push_valid_i = 1'b1;
      bus.push_fu_i    = 1'b1;
      bus.push_beats_i = 16'd1;
      bus.push_id_i    = 3'd7;
      beat("full_pop", 8'h77, 1'b1, 1'b1);
      chk("full_no_passthru_len", 32'(tq.size()), 32'd3);
      bus.push_valid_i = 1'b0;
      chk("full_after_pop_ready", 32'(bus.push_ready_o), 32'd1);
      push("zero_push", 1'b1, 16'd0, 3'd6);
      idle("zero_err_clear");
      for (int i = 0; i < 3; i++) beat("full_drain", 8'(8'h10 + i), 1'b1, 1'b1);
      idle("drained");

      // Mid-operation reset after 1 of 3 beats
      push("mr_push", 1'b0, 16'd3, 3'd6);
      beat("mr_b0", 8'h9A, 1'b1, 1'b1);
      rst = 1'b1;
      bus.mask_valid_i = 1'b1;
      #1;
      chk("mr_in_rst_mask_ready", 32'(bus.mask_ready_o), 32'd0);
      chk("mr_in_rst_push_ready", 32'(bus.push_ready_o), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tq.delete();
      m_alu = 0;
      m_mfpu = 0;
      chk_head("mr_after");
      chk("mr_after_alu_valid", 32'(bus.alu_mask_valid_o), 32'd0);
      chk("mr_after_mask_ready", 32'(bus.mask_ready_o), 32'd0);
      chk("mr_after_err", 32'(bus.err_o), 32'd0);
      chk_perf("mr_after");
      bus.mask_valid_i = 1'b0;
      push("mr_new", 1'b1, 16'd1, 3'd7);
      beat("mr_new_b0", 8'hE1, 1'b0, 1'b1);

      // Beat counters: 5 ALU and 3 MFPU beats since the reset
      push("perf_p0", 1'b0, 16'd5, 3'd1);
      push("perf_p1", 1'b1, 16'd2, 3'd2);
      for (int i = 0; i < 7; i++) beat("perf_b", 8'(i * 17), 1'b1, 1'b1);
      chk("perf_model_alu", 32'(m_alu), 32'd5);
      chk_perf("perf");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
